bram2axi: RTL and testbench
===========================

BRAM2AXI -- requirements
Module: bram2axi

Interface
REQ-001 Parameter H_ACTIVE, 640, pixels per line.
REQ-002 Parameter V_ACTIVE, 480, lines per frame; H_ACTIVE*V_ACTIVE SHALL NOT exceed 2^19.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port RESET  input  1  one clock; reset is synchronous and active-high.
REQ-005 Port start  input  1  frame readout request pulse.
REQ-006 Port busy  output  1  high from the accepted start until the final byte handshake.
REQ-007 Port done  output  1  one-cycle pulse after the final byte of the frame.
REQ-008 Port rd_en  output  1  framebuffer read enable.
REQ-009 Port rd_index  output  19  framebuffer pixel address.
REQ-010 Port rd_data  input  15  pixel {R[4:0],G[4:0],B[4:0]}, valid exactly one cycle after rd_en.
REQ-011 Port m_tdata  output  8  stream byte.
REQ-012 Port m_tvalid  output  1  AXI-Stream valid.
REQ-013 Port m_tready  input  1  AXI-Stream ready.
REQ-014 Port m_tlast  output  1  high on the last byte of the frame.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN.
REQ-016 IDLE->RUN on start; rd_index SHALL be 0 on the first read; start SHALL be ignored in RUN and DRAIN.
REQ-017 RUN: assert rd_en when fewer than 2 pixels are held or in flight; increment rd_index after each read.
REQ-018 RUN->DRAIN in the cycle the read at index FRAME_PIXELS-1 issues; no rd_en in DRAIN or IDLE.
REQ-019 DRAIN->IDLE on the handshake of the final byte; done SHALL pulse the next cycle and busy SHALL deassert in the same cycle.
REQ-020 Returned pixels SHALL enter a 2-entry buffer; reads SHALL never be issued that would overflow it, so no pixel is dropped under any m_tready pattern.
REQ-021 Each pixel SHALL emit 2 bytes: first {1'b0,R,G[4:3]}, then {G[2:0],B}.
REQ-022 A byte advances only on m_tvalid&&m_tready; m_tdata/m_tlast SHALL hold stable while m_tvalid&&!m_tready.
REQ-023 With m_tready held high, the first byte SHALL appear 2 cycles after start and bytes SHALL be continuous (1 byte/cycle) until the frame ends.
REQ-024 m_tlast SHALL be high only on the 2nd byte of pixel FRAME_PIXELS-1.
REQ-025 Output bytes SHALL preserve BRAM address order exactly.

Reset
REQ-026 RESET SHALL force IDLE, and clear rd_index to 0, the buffer, and the byte phase.
REQ-027 While RESET is high: busy, done, rd_en, m_tvalid and m_tlast SHALL be 0 and m_tdata SHALL be 8'h00.
REQ-028 RESET mid-frame SHALL abandon the frame without a done pulse; the next start SHALL restart at index 0.

Configuration
REQ-029 Macro BRAM2AXI_TUSER_SOF_EN defined: add port m_tuser (output, 1), high only on the first byte of each frame and held stable under backpressure.
REQ-030 Macro BRAM2AXI_TUSER_SOF_EN undefined: port m_tuser and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Shared package fb_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, IDX_W=19, PIX_W=15, FRAME_PIXELS, and the FSM state typedef.
REQ-032 The 2-entry pixel buffer SHALL be the sub-module pix_skid_fifo (push, pop, full, empty, 15-bit data).

Verification
REQ-033 H=4, V=2, BRAM[i]={i,i,i}, tready=1, start pulse -> 16 bytes over 16 consecutive cycles; pixel 3 gives 8'h0C, 8'h63; tlast on byte 16 only; done pulses one cycle later.
REQ-034 Same setup with tready toggling 1,0,1,0 -> identical byte sequence; no byte is duplicated or lost; tdata is stable while stalled.
REQ-035 tready=0 for 20 cycles after start -> at most 2 pixels are requested (rd_index <= 2); stream resumes intact once tready rises.
REQ-036 start re-pulsed mid-frame -> ignored; exactly one frame is emitted and one done pulse.
REQ-037 RESET asserted at byte 5 -> m_tvalid=0 in the following cycle; a new start restarts from index 0 and the first byte equals pixel 0's high byte.
REQ-038 With BRAM2AXI_TUSER_SOF_EN defined, two back-to-back frames -> m_tuser is high on exactly byte 1 of each frame.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and FSM state encoding for the BRAM-to-AXI-Stream readout.
package fb_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned IDX_W        = 19;
   localparam int unsigned PIX_W        = 15;
   localparam int unsigned FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel buffer between the framebuffer read port and the byte serialiser.
module pix_skid_fifo
   import fb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [PIX_W-1:0] push_data,
   input  logic             pop,
   output logic [PIX_W-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   logic [PIX_W-1:0] mem_q [2];
   logic [PIX_W-1:0] mem_d [2];
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   always_comb begin
      full     = (cnt_q == 2'd2);
      empty    = (cnt_q == 2'd0);
      pop_data = mem_q[rd_q];
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      mem_d    = mem_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      if (push_ok) begin
         mem_d[wr_q] = push_data;
         wr_d        = ~wr_q;
      end
      if (pop_ok) begin
         rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bram2axi.sv
// Streams one framebuffer frame out as AXI-Stream bytes, two bytes per 15-bit pixel.
// Optional start-of-frame m_tuser port enabled by defining BRAM2AXI_TUSER_SOF_EN.
module bram2axi
   import fb_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [IDX_W-1:0] rd_index,
   input  logic [PIX_W-1:0] rd_data,
   output logic [7:0]       m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast
`ifdef BRAM2AXI_TUSER_SOF_EN
   ,
   output logic             m_tuser
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_ACTIVE * V_ACTIVE - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0] pix_out_q, pix_out_d;
   logic             rd_vld_q, rd_vld_d;
   logic             phase_q, phase_d;
   logic             done_q, done_d;

   logic [PIX_W-1:0] head;
   logic             fifo_full, fifo_empty;
   logic [1:0]       held;
   logic             rd_fire, hs, pop, last_byte;

   pix_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (RESET),
      .push      (rd_vld_q),
      .push_data (rd_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      // Count reads still in flight so the buffer can never be asked to hold a third pixel.
      held      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
      rd_fire   = (state_q == ST_RUN) && ((held + {1'b0, rd_vld_q}) < 2'd2);
      hs        = !fifo_empty && m_tready;
      last_byte = phase_q && (pix_out_q == LAST_IDX);
      pop       = hs && phase_q;

      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      pix_out_d = pix_out_q;
      rd_vld_d  = rd_fire;
      phase_d   = hs ? ~phase_q : phase_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               rd_idx_d = '0;
            end
         end
         ST_RUN: begin
            if (rd_fire && (rd_idx_q == LAST_IDX)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (hs && last_byte) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rd_fire) begin
         rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
      end
      if (pop) begin
         pix_out_d = last_byte ? '0 : pix_out_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         rd_idx_q  <= '0;
         pix_out_q <= '0;
         rd_vld_q  <= 1'b0;
         phase_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_idx_q  <= rd_idx_d;
         pix_out_q <= pix_out_d;
         rd_vld_q  <= rd_vld_d;
         phase_q   <= phase_d;
         done_q    <= done_d;
      end
   end

   // Outputs are gated by RESET so they read zero during the reset cycle itself.
   always_comb begin
      busy     = (state_q != ST_IDLE) && !RESET;
      done     = done_q && !RESET;
      rd_en    = rd_fire && !RESET;
      rd_index = rd_idx_q;
      m_tvalid = !fifo_empty && !RESET;
      m_tlast  = m_tvalid && last_byte;
      if (!m_tvalid) begin
         m_tdata = '0;
      end else if (phase_q) begin
         m_tdata = head[7:0];
      end else begin
         m_tdata = {1'b0, head[14:10], head[9:8]};
      end
`ifdef BRAM2AXI_TUSER_SOF_EN
      m_tuser  = m_tvalid && !phase_q && (pix_out_q == '0);
`endif
   end

endmodule

// File: tb/tb_bram2axi.sv
// Scoreboard bench for bram2axi on a 4x2 frame with BRAM[i] = {i,i,i}.
module tb_bram2axi;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       user;
   } exp_t;

   // Hand-computed byte stream of a 4x2 frame where pixel i = {i,i,i}.
   localparam logic [7:0] EXP_BYTES [16] = '{
      8'h00, 8'h00, 8'h04, 8'h21, 8'h08, 8'h42, 8'h0C, 8'h63,
      8'h10, 8'h84, 8'h14, 8'hA5, 8'h18, 8'hC6, 8'h1C, 8'hE7
   };

   logic        clk = 1'b0;
   logic        RESET;
   logic        start;
   logic        busy, done, rd_en;
   logic [18:0] rd_index;
   logic [14:0] rd_data = '0;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
`ifdef BRAM2AXI_TUSER_SOF_EN
   logic        m_tuser;
`endif

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   rd_cnt = 0;
   int   byte_idx = 0;
   int   first_cyc = 0;
   int   last_hs_cyc = 0;
   int   mode = 0;
   exp_t exp_q[$];
   exp_t e;
   logic       stall_pending = 1'b0;
   logic [7:0] stall_data = '0;
   logic       stall_last = 1'b0;

   bram2axi #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
      .clk      (clk),
      .RESET    (RESET),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_index (rd_index),
      .rd_data  (rd_data),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast)
`ifdef BRAM2AXI_TUSER_SOF_EN
      ,
      .m_tuser  (m_tuser)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rd_en) rd_data <= {rd_index[4:0], rd_index[4:0], rd_index[4:0]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (RESET) begin
         chk("reset_outputs", {19'd0, busy, done, rd_en, m_tvalid, m_tlast, m_tdata}, 32'd0);
         exp_q.delete();
         stall_pending = 1'b0;
         byte_idx = 0;
      end else begin
         if (rd_en) rd_cnt++;
         if (stall_pending)
            chk("stall_hold", {23'd0, m_tvalid, m_tlast, m_tdata}, {23'd0, 1'b1, stall_last, stall_data});
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {24'd0, m_tdata}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("tdata", {24'd0, m_tdata}, {24'd0, e.data});
               chk("tlast", {31'd0, m_tlast}, {31'd0, e.last});
`ifdef BRAM2AXI_TUSER_SOF_EN
               chk("tuser", {31'd0, m_tuser}, {31'd0, e.user});
`endif
            end
            if (byte_idx == 0) first_cyc = cyc;
            last_hs_cyc = cyc;
            byte_idx = m_tlast ? 0 : byte_idx + 1;
            stall_pending = 1'b0;
         end else if (m_tvalid) begin
            stall_pending = 1'b1;
            stall_data = m_tdata;
            stall_last = m_tlast;
         end else begin
            stall_pending = 1'b0;
         end
         if (done) begin
            done_cnt++;
            chk("done_timing", cyc, last_hs_cyc + 1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      exp_t t;
      for (int i = 0; i < 16; i++) begin
         t.data = EXP_BYTES[i];
         t.last = (i == 15);
         t.user = (i == 0);
         exp_q.push_back(t);
      end
   endtask

   task automatic pulse_start(output int sc);
      start = 1'b1;
      sc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int limit);
      int n;
      n = 0;
      while (done_cnt <= base && n < limit) begin
         tick();
         n++;
         case (mode)
            1: m_tready = ~m_tready;
            default: m_tready = 1'b1;
         endcase
      end
      if (done_cnt <= base) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, d, r0, n;
      RESET = 1'b1;
      start = 1'b0;
      m_tready = 1'b0;
      repeat (3) tick();
      RESET = 1'b0;
      tick();
      chk("idle_rd_index", {13'd0, rd_index}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Continuous stream with tready held high.
      mode = 0;
      m_tready = 1'b1;
      push_frame();
      d = done_cnt;
      pulse_start(sc);
      wait_done(d, 100);
      chk("first_byte_latency", first_cyc, sc + 3);
      chk("continuous_bytes", last_hs_cyc - first_cyc, 32'd15);
      repeat (3) tick();
      chk("t1_queue_empty", exp_q.size(), 32'd0);

      // Alternating ready.
      mode = 1;
      m_tready = 1'b1;
      push_frame();
      d = done_cnt;
      pulse_start(sc);
      wait_done(d, 200);
      repeat (3) tick();
      chk("t2_queue_empty", exp_q.size(), 32'd0);

      // Long stall right after start.
      mode = 0;
      m_tready = 1'b0;
      push_frame();
      d = done_cnt;
      r0 = rd_cnt;
      pulse_start(sc);
      repeat (20) tick();
      chk("stall_reads", rd_cnt - r0, 32'd2);
      chk("stall_rd_index", {13'd0, rd_index}, 32'd2);
      m_tready = 1'b1;
      wait_done(d, 100);
      repeat (3) tick();
      chk("t3_queue_empty", exp_q.size(), 32'd0);

      // start re-pulsed mid-frame must be ignored.
      push_frame();
      d = done_cnt;
      pulse_start(sc);
      repeat (6) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(d, 100);
      repeat (30) tick();
      chk("t4_single_done", done_cnt - d, 32'd1);
      chk("t4_queue_empty", exp_q.size(), 32'd0);

      // Reset while byte 5 is on the bus.
      push_frame();
      d = done_cnt;
      pulse_start(sc);
      n = 0;
      while (byte_idx != 4 && n < 50) begin
         tick();
         n++;
      end
      chk("t5_reached_byte5", byte_idx, 32'd4);
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tick();
      chk("t5_tvalid_after_reset", {31'd0, m_tvalid}, 32'd0);
      chk("t5_rd_index_after_reset", {13'd0, rd_index}, 32'd0);
      chk("t5_busy_after_reset", {31'd0, busy}, 32'd0);
      chk("t5_no_done", done_cnt - d, 32'd0);
      push_frame();
      pulse_start(sc);
      wait_done(d, 100);
      chk("t5_restart_latency", first_cyc, sc + 3);
      repeat (3) tick();
      chk("t5_queue_empty", exp_q.size(), 32'd0);

      // Two back-to-back frames.
      push_frame();
      push_frame();
      d = done_cnt;
      pulse_start(sc);
      wait_done(d, 100);
      pulse_start(sc);
      wait_done(d + 1, 100);
      repeat (3) tick();
      chk("t6_two_dones", done_cnt - d, 32'd2);
      chk("t6_queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
